ucontrol_sequencer: RTL

Multicycle control sequencer for the register scratchpath. Consumes the IR fields (OP, RS1, RS2, RD, IR13) the scratchpath exposes. Drives back the register-write decoder select, the bus A and bus B mux selects, the C-bus source select and the ALU operation. Also owns the memory request handshake for instruction fetch, load and store.

---
 rtl/ucontrol_pkg.sv | 53 +++++
 rtl/ucontrol_sequencer_if.sv | 41 ++++
 rtl/ucontrol_sequencer_decode.sv | 39 +++
 rtl/ucontrol_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ucontrol_pkg.sv
// Shared constants and types for the multicycle control sequencer.
package ucontrol_pkg;

  // Opcodes
  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_XOR  = 8'h04;
  localparam logic [7:0] OP_LD   = 8'h10;
  localparam logic [7:0] OP_ST   = 8'h11;
  localparam logic [7:0] OP_HALT = 8'hFF;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_INC4  = 4'd5;
  localparam logic [3:0] ALU_PASSA = 4'd6;

  // Register select codes
  localparam logic [3:0] REG_ZERO    = 4'd0;
  localparam logic [3:0] REG_PC      = 4'd8;
  localparam logic [3:0] REG_TEMP0   = 4'd9;
  localparam logic [3:0] REG_IR      = 4'd13;
  localparam logic [3:0] REG_NOWRITE = 4'd15;

  // Highest register number an instruction field may name
  localparam int unsigned GPR_MAX = 7;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    ADDR,
    MEM,
    PCINC,
    HALT
  } state_e;

  // Instruction class; exactly one flag is set for any IR contents
  typedef struct packed {
    logic       alu;
    logic       ld;
    logic       st;
    logic       halt;
    logic       illegal;
    logic [3:0] alu_op;
  } op_class_t;

endpackage

// File: rtl/ucontrol_sequencer_if.sv
// IR fields from the scratchpath and the control/memory handshake back to it.
interface ucontrol_sequencer_if #(
  parameter int unsigned DATAWIDTH_BUS_REG_IR        = 5,
  parameter int unsigned DATAWIDTH_BUS_REG_IR_OP     = 8,
  parameter int unsigned DATAWIDTH_DECODER_SELECTION = 4,
  parameter int unsigned DATAWIDTH_MUX_SELECTION     = 4,
  parameter int unsigned DATAWIDTH_ALU_SELECTION     = 4
);
  logic [DATAWIDTH_BUS_REG_IR_OP-1:0]     uControl_IR_OP;
  logic [DATAWIDTH_BUS_REG_IR-1:0]        uControl_IR_RS1;
  logic [DATAWIDTH_BUS_REG_IR-1:0]        uControl_IR_RS2;
  logic [DATAWIDTH_BUS_REG_IR-1:0]        uControl_IR_RD;
  logic                                   uControl_IR_IR13;
  logic                                   uControl_MEM_Ack;
  logic [DATAWIDTH_DECODER_SELECTION-1:0] uControl_Selector_Decoder;
  logic [DATAWIDTH_MUX_SELECTION-1:0]     uControl_Selector_MUX_A;
  logic [DATAWIDTH_MUX_SELECTION-1:0]     uControl_Selector_MUX_B;
  logic                                   uControl_Selector_MUXC;
  logic [DATAWIDTH_ALU_SELECTION-1:0]     uControl_ALU_Op;
  logic                                   uControl_MEM_Req;
  logic                                   uControl_MEM_WriteEn;
  logic                                   uControl_Halted;

  // Sequencer side
  modport master (
    input  uControl_IR_OP, uControl_IR_RS1, uControl_IR_RS2, uControl_IR_RD,
           uControl_IR_IR13, uControl_MEM_Ack,
    output uControl_Selector_Decoder, uControl_Selector_MUX_A, uControl_Selector_MUX_B,
           uControl_Selector_MUXC, uControl_ALU_Op, uControl_MEM_Req,
           uControl_MEM_WriteEn, uControl_Halted
  );

  // Scratchpath / memory side
  modport slave (
    output uControl_IR_OP, uControl_IR_RS1, uControl_IR_RS2, uControl_IR_RD,
           uControl_IR_IR13, uControl_MEM_Ack,
    input  uControl_Selector_Decoder, uControl_Selector_MUX_A, uControl_Selector_MUX_B,
           uControl_Selector_MUXC, uControl_ALU_Op, uControl_MEM_Req,
           uControl_MEM_WriteEn, uControl_Halted
  );
endinterface

// File: rtl/ucontrol_sequencer_decode.sv
// Combinational instruction classifier: opcode and register-field legality.
module ucontrol_decode
  import ucontrol_pkg::*;
#(
  parameter int unsigned RW  = 5,
  parameter int unsigned OPW = 8
) (
  input  logic [OPW-1:0] op_i,
  input  logic [RW-1:0]  rs1_i,
  input  logic [RW-1:0]  rs2_i,
  input  logic [RW-1:0]  rd_i,
  output op_class_t      cls_o
);
  logic bad_reg;

  // Classify the opcode; any out-of-range register field overrides to illegal
  always_comb begin
    cls_o        = '0;
    cls_o.alu_op = ALU_PASSA;
    bad_reg      = (rs1_i > RW'(GPR_MAX)) || (rs2_i > RW'(GPR_MAX)) ||
                   (rd_i > RW'(GPR_MAX));
    case (op_i)
      OPW'(OP_ADD):  begin cls_o.alu = 1'b1; cls_o.alu_op = ALU_ADD; end
      OPW'(OP_SUB):  begin cls_o.alu = 1'b1; cls_o.alu_op = ALU_SUB; end
      OPW'(OP_AND):  begin cls_o.alu = 1'b1; cls_o.alu_op = ALU_AND; end
      OPW'(OP_OR):   begin cls_o.alu = 1'b1; cls_o.alu_op = ALU_OR;  end
      OPW'(OP_XOR):  begin cls_o.alu = 1'b1; cls_o.alu_op = ALU_XOR; end
      OPW'(OP_LD):   cls_o.ld   = 1'b1;
      OPW'(OP_ST):   cls_o.st   = 1'b1;
      OPW'(OP_HALT): cls_o.halt = 1'b1;
      default:       cls_o.illegal = 1'b1;
    endcase
    if (bad_reg) begin
      cls_o         = '0;
      cls_o.alu_op  = ALU_PASSA;
      cls_o.illegal = 1'b1;
    end
  end
endmodule

// File: rtl/ucontrol_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC|ADDR-MEM/PCINC with HALT trap.
module ucontrol_sequencer
  import ucontrol_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS_REG_IR        = 5,
  parameter int unsigned DATAWIDTH_BUS_REG_IR_OP     = 8,
  parameter int unsigned DATAWIDTH_DECODER_SELECTION = 4,
  parameter int unsigned DATAWIDTH_MUX_SELECTION     = 4,
  parameter int unsigned DATAWIDTH_ALU_SELECTION     = 4
) (
  input logic                  uDataPath_CLOCK_50,
  input logic                  uDATAPATH_RESET_InHigh,
  ucontrol_sequencer_if.master bus
);
  localparam int unsigned DW = DATAWIDTH_DECODER_SELECTION;
  localparam int unsigned MW = DATAWIDTH_MUX_SELECTION;
  localparam int unsigned AW = DATAWIDTH_ALU_SELECTION;

  state_e    state_q;
  op_class_t cls;

  logic [DW-1:0] dec_c;
  logic [MW-1:0] mux_a_c;
  logic [MW-1:0] mux_b_c;
  logic [MW-1:0] b_operand;
  logic [AW-1:0] alu_c;
  logic          muxc_c;
  logic          req_c;
  logic          we_c;
  logic          halted_c;

  ucontrol_decode #(
    .RW  (DATAWIDTH_BUS_REG_IR),
    .OPW (DATAWIDTH_BUS_REG_IR_OP)
  ) u_decode (
    .op_i  (bus.uControl_IR_OP),
    .rs1_i (bus.uControl_IR_RS1),
    .rs2_i (bus.uControl_IR_RS2),
    .rd_i  (bus.uControl_IR_RD),
    .cls_o (cls)
  );

  assign b_operand = bus.uControl_IR_IR13 ? MW'(REG_IR) : MW'(bus.uControl_IR_RS2);

  // State register; memory states advance only on Ack, HALT is sticky until reset
  always_ff @(posedge uDataPath_CLOCK_50 or posedge uDATAPATH_RESET_InHigh) begin
    if (uDATAPATH_RESET_InHigh) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:  if (bus.uControl_MEM_Ack) state_q <= DECODE;
        DECODE: begin
          if (cls.illegal || cls.halt) state_q <= HALT;
          else if (cls.alu)            state_q <= EXEC;
          else                         state_q <= ADDR;
        end
        EXEC:   state_q <= PCINC;
        ADDR:   state_q <= MEM;
        MEM:    if (bus.uControl_MEM_Ack) state_q <= PCINC;
        PCINC:  state_q <= FETCH;
        HALT:   state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Output decode of the state; reset is folded in combinationally so a
  // pending request drops the moment reset rises, not at the next edge
  always_comb begin
    req_c    = 1'b0;
    we_c     = 1'b0;
    halted_c = 1'b0;
    muxc_c   = 1'b0;
    dec_c    = DW'(REG_NOWRITE);
    mux_a_c  = '0;
    mux_b_c  = '0;
    alu_c    = AW'(ALU_PASSA);
    if (!uDATAPATH_RESET_InHigh) begin
      case (state_q)
        FETCH: begin
          req_c   = 1'b1;
          mux_a_c = MW'(REG_PC);
          muxc_c  = 1'b1;
          if (bus.uControl_MEM_Ack) dec_c = DW'(REG_IR);
        end
        EXEC: begin
          mux_a_c = MW'(bus.uControl_IR_RS1);
          mux_b_c = b_operand;
          alu_c   = AW'(cls.alu_op);
          if (bus.uControl_IR_RD != '0) dec_c = DW'(bus.uControl_IR_RD);
        end
        ADDR: begin
          mux_a_c = MW'(bus.uControl_IR_RS1);
          mux_b_c = b_operand;
          alu_c   = AW'(ALU_ADD);
          dec_c   = DW'(REG_TEMP0);
        end
        MEM: begin
          req_c   = 1'b1;
          mux_a_c = MW'(REG_TEMP0);
          if (cls.st) begin
            we_c    = 1'b1;
            mux_b_c = MW'(bus.uControl_IR_RD);
          end else begin
            muxc_c = 1'b1;
            if (bus.uControl_MEM_Ack && (bus.uControl_IR_RD != '0))
              dec_c = DW'(bus.uControl_IR_RD);
          end
        end
        PCINC: begin
          mux_a_c = MW'(REG_PC);
          alu_c   = AW'(ALU_INC4);
          dec_c   = DW'(REG_PC);
        end
        HALT:    halted_c = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.uControl_Selector_Decoder = dec_c;
  assign bus.uControl_Selector_MUX_A   = mux_a_c;
  assign bus.uControl_Selector_MUX_B   = mux_b_c;
  assign bus.uControl_Selector_MUXC    = muxc_c;
  assign bus.uControl_ALU_Op           = alu_c;
  assign bus.uControl_MEM_Req          = req_c;
  assign bus.uControl_MEM_WriteEn      = we_c;
  assign bus.uControl_Halted           = halted_c;

endmodule
